lector7s_bcd: RTL
=================

# lector7s_bcd

Decodes the multiplexed seven-segment display bus back into BCD digits. It samples the active-low segment lines (gfedcba) and the active-low digit-enable lines, and waits for each digit's pattern to be stable. It then inverts the team's segment encoding, stores one BCD nibble per digit and strobes a frame-complete flag once every digit has been captured. It sits on the display side of the board, as a loopback checker and for reading external displays that use the same encoding.

## Interface
- DIGITOS, 4: number of multiplexed digits; minimum 1.
- ESTABLE, 3: consecutive identical synchronized samples required before a capture; minimum 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- segmentos  input  7  segment lines gfedcba, active-low; asynchronous to clk.
- anodos  input  DIGITOS  digit enables, active-low, bit i = digit i; asynchronous to clk.
- bcd_out  output  4*DIGITOS  captured digits; bits [4i+3:4i] = digit i.
- valido  output  1  one-cycle strobe: every digit captured since the previous strobe.
- error_dig  output  DIGITOS  bit i set when digit i's most recent capture was an unrecognised pattern.

## Operation
- **Synchronizer:** two-flop synchronizer on segmentos and anodos.
  - Stage registers reset to all-ones (idle bus: no digit enabled, all segments off).
- **Digit selection:** a sample is a candidate only if exactly one anodos bit is 0.
  - Zero or several enables low: stability counter cleared, no capture.
- **Stability counter:** counts consecutive edges on which the synchronized pair (anodos, segmentos) equals the previous sample.
  - Any change in either field restarts the count.
  - Saturates once a capture has occurred; at most one capture per dwell.
  - A new dwell starts only after the pair changes.
- **Decode on capture:**
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9
- **Valid pattern:** write the nibble to slot i and clear error_dig[i].
- **Any other pattern (including blank 1111111):** slot i unchanged, set error_dig[i].
- **Frame tracking:** an internal seen[DIGITOS-1:0] register sets bit i on every capture of digit i, valid or not.
  - On the edge where a capture makes seen all-ones: seen is cleared and valido is registered high for exactly one cycle.
- **Recapture:** a digit captured twice within one frame overwrites its slot; seen is unaffected.
- **Single digit:** with DIGITOS=1, every capture produces valido.

## Timing
- **Reset values:** bcd_out=0, valido=0, error_dig=0, seen=0, counter=0.
  - rst_n low mid-frame discards partial captures immediately.
  - No capture can occur until ESTABLE+1 edges after rst_n deassertion with a stable single-digit input.
- **Latency:** pair held constant from before rising edge 0 → bcd_out/error_dig update on edge ESTABLE+1.
  - Default ESTABLE=3: update on edge 4.
- **valido timing:** rises on the same edge as the completing capture, so updated bcd_out and valido are visible together.
  - Falls on the next edge.
- **Glitch filtering:** patterns shorter than ESTABLE+1 cycles are never captured.
  - Segment changes during a dwell, after capture, start a new dwell and can be captured again.
- **No simultaneous captures:** at most one capture per cycle, since only one enable may be low.

## Test plan
- **Reset:** rst_n=0 with random bus activity → all outputs 0 throughout; release with the bus idle (anodos=1111) → no capture, valido stays 0.
- **Basic frame:** DIGITOS=4, dwell 8 cycles each, digit0..3 showing 2,0,2,5 (0100100,1000000,0100100,0010010) → bcd_out=16'h5202 and a single valido pulse on the edge of the digit3 capture (edge 4 of its dwell).
- **Latency/glitch:**
  - Digit1 pattern 0000010 held exactly 4 cycles → captured, nibble 6, on edge 4.
  - Held 3 cycles → not captured.
  - 1-cycle segment glitch mid-dwell → the glitch value is never stored.
- **Invalid pattern:** digit2 shows 1111111 → error_dig=0100, slot2 keeps its prior value, valido still fires at frame end; the next frame with a valid 9 (0011000) on digit2 → error_dig=0000, slot2=9.
- **Multiple enables:** anodos=1001 held 10 cycles → no capture, seen unchanged; then a normal frame → exactly one valido.
- **Reset mid-frame:** digits 0,1 captured, then rst_n pulsed → bcd_out=0, seen cleared; the next full frame is required before valido.

Source files
------------

// File: rtl/lector7s_bcd.sv
// Reads a multiplexed active-low seven-segment bus back into one BCD nibble per digit.
// Latency: a pattern held from before edge 0 is captured on edge ESTABLE+1; valido rises on that same edge.
// Backpressure: none, the bus is sampled every cycle and valido is a single-cycle strobe.
module lector7s_bcd #(
    parameter int DIGITOS = 4,
    parameter int ESTABLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             segmentos,
    input  logic [DIGITOS-1:0]     anodos,
    output logic [4*DIGITOS-1:0]   bcd_out,
    output logic                   valido,
    output logic [DIGITOS-1:0]     error_dig
);

    localparam int CW = $clog2(ESTABLE + 1);

    logic [6:0]         seg_m, seg_s;
    logic [DIGITOS-1:0] an_m, an_s;
    logic [CW-1:0]      cnt;
    logic [DIGITOS-1:0] seen;

    logic               igual;
    logic               unico;
    logic               captura;
    logic [DIGITOS-1:0] sel;
    logic [DIGITOS-1:0] seen_next;
    logic [3:0]         nibble;
    logic               patron_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            an_m  <= '1;
            an_s  <= '1;
        end else begin
            seg_m <= segmentos;
            seg_s <= seg_m;
            an_m  <= anodos;
            an_s  <= an_m;
        end
    end

    // Comparing the two stages lets the sample just entering count toward stability,
    // so a pattern must occupy ESTABLE+1 input cycles; the stored data always comes from the settled stage.
    always_comb begin
        sel       = ~an_s;
        unico     = $onehot(sel);
        igual     = (seg_m == seg_s) && (an_m == an_s);
        captura   = igual && unico && (cnt == CW'(ESTABLE - 1));
        seen_next = seen | sel;
    end

    always_comb begin
        nibble    = 4'd0;
        patron_ok = 1'b1;
        case (seg_s)
            7'b1000000: nibble = 4'd0;
            7'b1111001: nibble = 4'd1;
            7'b0100100: nibble = 4'd2;
            7'b0110000: nibble = 4'd3;
            7'b0011001: nibble = 4'd4;
            7'b0010010: nibble = 4'd5;
            7'b0000010: nibble = 4'd6;
            7'b1111000: nibble = 4'd7;
            7'b0000000: nibble = 4'd8;
            7'b0011000: nibble = 4'd9;
            default:    patron_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            seen      <= '0;
            bcd_out   <= '0;
            error_dig <= '0;
            valido    <= 1'b0;
        end else begin
            // Saturating at ESTABLE holds off a second capture until the pair changes.
            if (!igual || !unico)
                cnt <= '0;
            else if (cnt != CW'(ESTABLE))
                cnt <= cnt + 1'b1;

            valido <= 1'b0;
            if (captura) begin
                for (int i = 0; i < DIGITOS; i++) begin
                    if (sel[i]) begin
                        if (patron_ok) begin
                            bcd_out[4*i +: 4] <= nibble;
                            error_dig[i]      <= 1'b0;
                        end else begin
                            error_dig[i]      <= 1'b1;
                        end
                    end
                end
                if (&seen_next) begin
                    seen   <= '0;
                    valido <= 1'b1;
                end else begin
                    seen   <= seen_next;
                end
            end
        end
    end

endmodule
